// File: rtl/ram_arbiter.sv
// Two-requester arbiter for the single RAM port: 1-cycle arbitration, then owner drives mem_*.
// Owner busy follows mem_busy in ISSUE. The grant is held through a read until its data is acked.
module ram_arbiter #(
    parameter int ADDR_W   = 24,
    parameter int DATA_W   = 16,
    parameter int RR       = 1,
    parameter int HOLD_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wr_data,
    input  logic              r0_wr_en,
    input  logic              r0_rd_en,
    output logic              r0_busy,
    output logic              r0_rd_ready,
    input  logic              r0_rd_ack,
    output logic [DATA_W-1:0] r0_rd_data,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wr_data,
    input  logic              r1_wr_en,
    input  logic              r1_rd_en,
    output logic              r1_busy,
    output logic              r1_rd_ready,
    input  logic              r1_rd_ack,
    output logic [DATA_W-1:0] r1_rd_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    output logic              mem_wr_en,
    output logic              mem_rd_en,
    input  logic              mem_busy,
    input  logic              mem_rd_ready,
    output logic              mem_rd_ack,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic [1:0]        grant
);

    localparam int CNT_W = $clog2(HOLD_MAX + 1);
    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT} state_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_owner_q, last_owner_d;
    logic [CNT_W-1:0]  hold_cnt_q, hold_cnt_d;

    logic              r0_req, r1_req;
    logic [ADDR_W-1:0] o_addr;
    logic [DATA_W-1:0] o_wr_data;
    logic              o_wr, o_rd, o_ack, o_req;
    logic [CNT_W-1:0]  hold_inc;
    logic              hold_more;

    assign r0_req     = r0_wr_en | r0_rd_en;
    assign r1_req     = r1_wr_en | r1_rd_en;
    assign o_addr     = owner_q ? r1_addr    : r0_addr;
    assign o_wr_data  = owner_q ? r1_wr_data : r0_wr_data;
    assign o_wr       = owner_q ? r1_wr_en   : r0_wr_en;
    assign o_rd       = owner_q ? r1_rd_en   : r0_rd_en;
    assign o_ack      = owner_q ? r1_rd_ack  : r0_rd_ack;
    assign o_req      = o_wr | o_rd;
    assign hold_inc   = hold_cnt_q + CNT_ONE;
    assign hold_more  = hold_inc < HOLD_LIM;
    assign r0_rd_data = mem_rd_data;
    assign r1_rd_data = mem_rd_data;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        hold_cnt_d   = hold_cnt_q;
        grant        = 2'b00;
        mem_addr     = '0;
        mem_wr_data  = '0;
        mem_wr_en    = 1'b0;
        mem_rd_en    = 1'b0;
        mem_rd_ack   = 1'b0;
        r0_busy      = 1'b1;
        r1_busy      = 1'b1;
        r0_rd_ready  = 1'b0;
        r1_rd_ready  = 1'b0;
        case (state_q)
            IDLE: begin
                if (r0_req | r1_req) begin
                    state_d    = ISSUE;
                    hold_cnt_d = '0;
                    if (RR != 0 && r0_req && r1_req) owner_d = ~last_owner_q;
                    else                             owner_d = ~r0_req;
                end
            end
            ISSUE: begin
                grant       = owner_q ? 2'b10 : 2'b01;
                mem_addr    = o_addr;
                mem_wr_data = o_wr_data;
                mem_wr_en   = o_wr;
                // a simultaneous read waits until the write has gone
                mem_rd_en   = o_rd & ~o_wr;
                if (owner_q) r1_busy = mem_busy;
                else         r0_busy = mem_busy;
                if (o_wr && !mem_busy) begin
                    hold_cnt_d = hold_inc;
                    if (!hold_more) begin
                        state_d      = IDLE;
                        last_owner_d = owner_q;
                    end
                end else if (o_rd && !mem_busy) begin
                    state_d = RDWAIT;
                end else if (!o_req) begin
                    state_d      = IDLE;
                    last_owner_d = owner_q;
                end
            end
            RDWAIT: begin
                grant       = owner_q ? 2'b10 : 2'b01;
                mem_addr    = o_addr;
                mem_wr_data = o_wr_data;
                mem_rd_ack  = o_ack & mem_rd_ready;
                if (owner_q) r1_rd_ready = mem_rd_ready;
                else         r0_rd_ready = mem_rd_ready;
                if (o_ack && mem_rd_ready) begin
                    hold_cnt_d = hold_inc;
                    if (hold_more && o_req) begin
                        state_d = ISSUE;
                    end else begin
                        state_d      = IDLE;
                        last_owner_d = owner_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // last_owner resets to r1 so r0 wins the first contested arbitration
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            hold_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            hold_cnt_q   <= hold_cnt_d;
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios plus randomized traffic against a reference model.
module tb_ram_arbiter;

    localparam int AW = 24;
    localparam int DW = 16;
    localparam int HOLD = 4;
    localparam int RR_MODE = 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [AW-1:0] r_addr [2];
    logic [DW-1:0] r_wdata[2];
    logic          r_wr   [2];
    logic          r_rd   [2];
    logic          r_ack  [2];
    logic          busy   [2];
    logic          rdy    [2];
    logic [DW-1:0] rdat   [2];
    logic          fp_busy[2];
    logic          fp_rdy [2];
    logic [DW-1:0] fp_rdat[2];

    logic [AW-1:0] mem_addr, fp_mem_addr;
    logic [DW-1:0] mem_wr_data, fp_mem_wr_data, mem_rd_data;
    logic          mem_wr_en, mem_rd_en, mem_rd_ack, fp_mem_wr_en, fp_mem_rd_en, fp_mem_rd_ack;
    logic          mem_busy, mem_rd_ready;
    logic [1:0]    grant, fp_grant;

    ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR(RR_MODE), .HOLD_MAX(HOLD)) u_rr (
        .clk(clk), .rst_n(rst_n),
        .r0_addr(r_addr[0]), .r0_wr_data(r_wdata[0]), .r0_wr_en(r_wr[0]), .r0_rd_en(r_rd[0]),
        .r0_busy(busy[0]), .r0_rd_ready(rdy[0]), .r0_rd_ack(r_ack[0]), .r0_rd_data(rdat[0]),
        .r1_addr(r_addr[1]), .r1_wr_data(r_wdata[1]), .r1_wr_en(r_wr[1]), .r1_rd_en(r_rd[1]),
        .r1_busy(busy[1]), .r1_rd_ready(rdy[1]), .r1_rd_ack(r_ack[1]), .r1_rd_data(rdat[1]),
        .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en),
        .mem_busy(mem_busy), .mem_rd_ready(mem_rd_ready), .mem_rd_ack(mem_rd_ack),
        .mem_rd_data(mem_rd_data), .grant(grant)
    );

    ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR(0), .HOLD_MAX(HOLD)) u_fp (
        .clk(clk), .rst_n(rst_n),
        .r0_addr(r_addr[0]), .r0_wr_data(r_wdata[0]), .r0_wr_en(r_wr[0]), .r0_rd_en(r_rd[0]),
        .r0_busy(fp_busy[0]), .r0_rd_ready(fp_rdy[0]), .r0_rd_ack(r_ack[0]), .r0_rd_data(fp_rdat[0]),
        .r1_addr(r_addr[1]), .r1_wr_data(r_wdata[1]), .r1_wr_en(r_wr[1]), .r1_rd_en(r_rd[1]),
        .r1_busy(fp_busy[1]), .r1_rd_ready(fp_rdy[1]), .r1_rd_ack(r_ack[1]), .r1_rd_data(fp_rdat[1]),
        .mem_addr(fp_mem_addr), .mem_wr_data(fp_mem_wr_data), .mem_wr_en(fp_mem_wr_en),
        .mem_rd_en(fp_mem_rd_en), .mem_busy(mem_busy), .mem_rd_ready(mem_rd_ready),
        .mem_rd_ack(fp_mem_rd_ack), .mem_rd_data(mem_rd_data), .grant(fp_grant)
    );

    int checks = 0;
    int failures = 0;

    // reference model: owner index (-1 = nobody), read outstanding, last owner, accepted count
    int  m_own, m_last, m_cnt;
    bit  m_wait;
    // traffic generators / memory responder
    bit            acc_w[2], acc_r[2];
    logic [AW-1:0] rd_addr_exp[2];
    bit            mem_racc, mem_ack_ev, m_pend, rand_mode;
    int            m_lat, wr_accepts;
    logic [AW-1:0] m_raddr;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
        return a[15:0] ^ 16'hC35A ^ {a[23:16], a[23:16]};
    endfunction

    task automatic model_step();
        logic [1:0]    e_grant, e_busy, e_rdy;
        logic          e_wr, e_rd, e_ack, ob, b;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd;
        bit            req0, req1;
        e_grant = 2'b00; e_busy = 2'b11; e_rdy = 2'b00;
        e_wr = 1'b0; e_rd = 1'b0; e_ack = 1'b0; e_addr = '0; e_wd = '0;
        ob = m_own[0];
        if (m_own >= 0) begin
            e_grant = ob ? 2'b10 : 2'b01;
            e_addr  = r_addr[ob];
            e_wd    = r_wdata[ob];
            if (!m_wait) begin
                e_wr = r_wr[ob];
                e_rd = r_rd[ob] && !r_wr[ob];
                e_busy[ob] = mem_busy;
            end else begin
                e_rdy[ob] = mem_rd_ready;
                e_ack = r_ack[ob] && mem_rd_ready;
            end
        end
        chk("grant", 64'(grant), 64'(e_grant));
        chk("mem_wr_rd_en", 64'({mem_wr_en, mem_rd_en}), 64'({e_wr, e_rd}));
        chk("mem_addr", 64'(mem_addr), 64'(e_addr));
        chk("mem_wr_data", 64'(mem_wr_data), 64'(e_wd));
        chk("busy", 64'({busy[1], busy[0]}), 64'(e_busy));
        chk("rd_ready", 64'({rdy[1], rdy[0]}), 64'(e_rdy));
        chk("mem_rd_ack", 64'(mem_rd_ack), 64'(e_ack));
        chk("rd_data", 64'({rdat[1], rdat[0]}), 64'({mem_rd_data, mem_rd_data}));

        for (int i = 0; i < 2; i++) begin
            b = 1'(i);
            acc_w[b] = r_wr[b] && !busy[b];
            acc_r[b] = !r_wr[b] && r_rd[b] && !busy[b];
            if (acc_r[b]) rd_addr_exp[b] = r_addr[b];
            if (rand_mode && rdy[b] && r_ack[b])
                chk("rd_value", 64'(rdat[b]), 64'(mem_val(rd_addr_exp[b])));
        end
        mem_racc   = mem_rd_en && !mem_busy;
        mem_ack_ev = mem_rd_ack && mem_rd_ready;
        if (mem_racc) m_raddr = mem_addr;
        if (mem_wr_en && !mem_busy) wr_accepts++;

        req0 = r_wr[0] || r_rd[0];
        req1 = r_wr[1] || r_rd[1];
        if (m_own < 0) begin
            if (req0 || req1) begin
                if (req0 && req1) m_own = (RR_MODE != 0) ? 1 - m_last : 0;
                else              m_own = req0 ? 0 : 1;
                m_cnt  = 0;
                m_wait = 1'b0;
            end
        end else if (!m_wait) begin
            if (r_wr[ob] && !mem_busy) begin
                m_cnt++;
                if (m_cnt >= HOLD) begin m_last = m_own; m_own = -1; end
            end else if (r_rd[ob] && !mem_busy) begin
                m_wait = 1'b1;
            end else if (!r_wr[ob] && !r_rd[ob]) begin
                m_last = m_own; m_own = -1;
            end
        end else if (mem_rd_ready && r_ack[ob]) begin
            m_cnt++;
            m_wait = 1'b0;
            if (!(m_cnt < HOLD && (r_wr[ob] || r_rd[ob]))) begin m_last = m_own; m_own = -1; end
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            r_addr[i] = '0; r_wdata[i] = '0; r_wr[i] = 1'b0; r_rd[i] = 1'b0; r_ack[i] = 1'b0;
            acc_w[i] = 1'b0; acc_r[i] = 1'b0;
        end
        mem_busy = 1'b0; mem_rd_ready = 1'b0; mem_rd_data = '0;
        m_own = -1; m_wait = 1'b0; m_last = 1; m_cnt = 0;
        m_pend = 1'b0; mem_racc = 1'b0; mem_ack_ev = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic rand_drive();
        logic b;
        int   k;
        if (mem_ack_ev) begin mem_rd_ready = 1'b0; m_pend = 1'b0; end
        if (mem_racc) begin m_pend = 1'b1; m_lat = $urandom_range(0, 3); end
        if (m_pend && !mem_rd_ready) begin
            if (m_lat == 0) begin mem_rd_ready = 1'b1; mem_rd_data = mem_val(m_raddr); end
            else m_lat--;
        end
        if (!mem_rd_ready) mem_rd_data = 16'($urandom);
        mem_busy = ($urandom_range(0, 3) == 0);
        for (int i = 0; i < 2; i++) begin
            b = 1'(i);
            if (acc_w[b]) r_wr[b] = 1'b0;
            else if (acc_r[b]) r_rd[b] = 1'b0;
            else if ((r_wr[b] || r_rd[b]) && $urandom_range(0, 19) == 0) begin
                r_wr[b] = 1'b0; r_rd[b] = 1'b0;
            end
            if (!r_wr[b] && !r_rd[b] && $urandom_range(0, 2) == 0) begin
                k = $urandom_range(0, 3);
                r_wr[b]    = (k != 2);
                r_rd[b]    = (k >= 2);
                r_addr[b]  = 24'($urandom);
                r_wdata[b] = 16'($urandom);
            end
            r_ack[b] = ($urandom_range(0, 1) == 1);
        end
    endtask

    initial begin
        int w0;
        logic [1:0] e_rr, e_fp;
        rand_mode = 1'b0;
        wr_accepts = 0;
        rst_n = 1'b1;
        #1;
        rst_n = 1'b0;
        mem_busy = 1'b0; mem_rd_ready = 1'b0; mem_rd_data = '0;
        for (int i = 0; i < 2; i++) begin
            r_addr[i] = '0; r_wdata[i] = '0; r_wr[i] = 1'b0; r_rd[i] = 1'b0; r_ack[i] = 1'b0;
        end
        #1;
        chk("rst_grant", 64'(grant), 64'(2'b00));
        chk("rst_busy", 64'({busy[1], busy[0]}), 64'(2'b11));
        chk("rst_en", 64'({mem_wr_en, mem_rd_en}), 64'(2'b00));
        chk("rst_addr", 64'(mem_addr), 64'(0));
        chk("rst_wdata", 64'(mem_wr_data), 64'(0));
        chk("rst_rdy", 64'({rdy[1], rdy[0]}), 64'(2'b00));
        chk("rst_ack", 64'(mem_rd_ack), 64'(0));
        do_reset();

        // single r0 write
        r_addr[0] = 24'h000010; r_wdata[0] = 16'hBEEF; r_wr[0] = 1'b1; w0 = wr_accepts;
        chk("t2_r1_busy_idle", 64'(busy[1]), 64'(1));
        cyc();
        chk("t2_grant", 64'(grant), 64'(2'b01));
        chk("t2_wr_en", 64'(mem_wr_en), 64'(1));
        chk("t2_addr", 64'(mem_addr), 64'(24'h000010));
        chk("t2_data", 64'(mem_wr_data), 64'(16'hBEEF));
        chk("t2_r0_busy", 64'(busy[0]), 64'(0));
        chk("t2_r1_busy", 64'(busy[1]), 64'(1));
        cyc();
        r_wr[0] = 1'b0;
        #1;
        chk("t2_wr_en_off", 64'(mem_wr_en), 64'(0));
        chk("t2_r1_busy_after", 64'(busy[1]), 64'(1));
        cyc();
        chk("t2_wr_count", 64'(wr_accepts - w0), 64'(1));
        chk("t2_idle", 64'(grant), 64'(2'b00));

        // contested continuous writes: RR alternates, fixed priority starves r1
        do_reset();
        r_addr[0] = 24'h000100; r_addr[1] = 24'h000200; r_wr[0] = 1'b1; r_wr[1] = 1'b1;
        for (int c = 0; c < 20; c++) begin
            e_rr = (c % 5 == 0) ? 2'b00 : ((((c / 5) % 2) == 0) ? 2'b01 : 2'b10);
            e_fp = (c % 5 == 0) ? 2'b00 : 2'b01;
            chk("rr_grant", 64'(grant), 64'(e_rr));
            chk("fp_grant", 64'(fp_grant), 64'(e_fp));
            chk("fp_r1_busy", 64'(fp_busy[1]), 64'(1));
            cyc();
        end
        r_wr[0] = 1'b0; r_wr[1] = 1'b0;
        cyc();

        // r1 read held across data latency while r0 waits
        do_reset();
        r_addr[1] = 24'h000123; r_rd[1] = 1'b1;
        cyc();
        chk("t4_grant", 64'(grant), 64'(2'b10));
        chk("t4_rd_en", 64'(mem_rd_en), 64'(1));
        chk("t4_addr", 64'(mem_addr), 64'(24'h000123));
        cyc();
        r_rd[1] = 1'b0; r_wr[0] = 1'b1; r_addr[0] = 24'h000200; r_wdata[0] = 16'h1111; r_ack[0] = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("t4_hold_grant", 64'(grant), 64'(2'b10));
            chk("t4_r0_busy", 64'(busy[0]), 64'(1));
            cyc();
        end
        mem_rd_ready = 1'b1; mem_rd_data = 16'h5A5A;
        #1;
        chk("t4_grant_rdy", 64'(grant), 64'(2'b10));
        chk("t4_r1_rdy", 64'(rdy[1]), 64'(1));
        chk("t4_r0_rdy", 64'(rdy[0]), 64'(0));
        chk("t4_no_ack", 64'(mem_rd_ack), 64'(0));
        cyc();
        r_ack[1] = 1'b1;
        #1;
        chk("t4_r1_data", 64'(rdat[1]), 64'(16'h5A5A));
        chk("t4_ack", 64'(mem_rd_ack), 64'(1));
        cyc();
        r_ack[1] = 1'b0; r_ack[0] = 1'b0; mem_rd_ready = 1'b0;
        #1;
        chk("t4_idle", 64'(grant), 64'(2'b00));
        cyc();
        chk("t4_r0_after", 64'(grant), 64'(2'b01));
        cyc();
        r_wr[0] = 1'b0;
        cyc();

        // memory stall during ISSUE
        do_reset();
        r_addr[0] = 24'h000333; r_wdata[0] = 16'h3333; r_wr[0] = 1'b1; mem_busy = 1'b1; w0 = wr_accepts;
        cyc();
        for (int k = 0; k < 5; k++) begin
            chk("t5_busy", 64'(busy[0]), 64'(1));
            chk("t5_wr_en", 64'(mem_wr_en), 64'(1));
            cyc();
        end
        mem_busy = 1'b0;
        #1;
        chk("t5_busy_rel", 64'(busy[0]), 64'(0));
        cyc();
        r_wr[0] = 1'b0;
        cyc();
        chk("t5_wr_count", 64'(wr_accepts - w0), 64'(1));

        // asynchronous reset during a read wait
        do_reset();
        r_addr[0] = 24'h000042; r_rd[0] = 1'b1;
        cyc();
        cyc();
        r_rd[0] = 1'b0; mem_rd_ready = 1'b1; mem_rd_data = 16'h7777;
        #1;
        chk("t6_rdwait_grant", 64'(grant), 64'(2'b01));
        chk("t6_rdwait_rdy", 64'(rdy[0]), 64'(1));
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_grant", 64'(grant), 64'(2'b00));
        chk("t6_busy", 64'({busy[1], busy[0]}), 64'(2'b11));
        chk("t6_rdy", 64'({rdy[1], rdy[0]}), 64'(2'b00));
        chk("t6_en", 64'({mem_wr_en, mem_rd_en}), 64'(2'b00));
        chk("t6_ack", 64'(mem_rd_ack), 64'(0));
        chk("t6_addr", 64'(mem_addr), 64'(0));
        do_reset();
        r_wr[0] = 1'b1; r_wr[1] = 1'b1;
        cyc();
        chk("t6_first_win", 64'(grant), 64'(2'b01));
        r_wr[0] = 1'b0; r_wr[1] = 1'b0;
        cyc();
        cyc();

        // randomized traffic against the model
        do_reset();
        rand_mode = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            rand_drive();
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
